// File: rtl/rect_sum_reader.sv
// Rectangle-sum client of the integral-image window buffer.
// Fetches up to four corner values (D, B, C, A) and returns D - B - C + A.
module rect_sum_reader #(
  parameter int W_DATA        = 18,
  parameter int WINDOW_WIDTH  = 24,
  parameter int WINDOW_HEIGHT = 24,
  localparam int W_ADDR  = $clog2(WINDOW_WIDTH * WINDOW_HEIGHT),
  localparam int W_COORD = $clog2(((WINDOW_WIDTH > WINDOW_HEIGHT) ? WINDOW_WIDTH : WINDOW_HEIGHT) + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rect_valid,
  output logic               rect_ready,
  input  logic [W_COORD-1:0] rect_x,
  input  logic [W_COORD-1:0] rect_y,
  input  logic [W_COORD-1:0] rect_w,
  input  logic [W_COORD-1:0] rect_h,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic [W_ADDR-1:0]  addr_data,
  input  logic               rd_valid,
  output logic               rd_ready,
  input  logic [W_DATA-1:0]  rd_data,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [W_DATA-1:0]  sum_data,
  output logic               sum_err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_OUT} state_t;

  state_t               r_state, w_next;
  logic [W_COORD-1:0]   r_row_hi, r_row_lo, r_col_hi, r_col_lo;
  logic [3:0]           r_todo;  // remaining corners, bit0..3 = D, B, C, A
  logic [W_DATA-1:0]    r_acc;
  logic                 r_err;

  logic [W_COORD:0]     w_x_end, w_y_end;
  logic                 w_illegal;
  logic [3:0]           w_cur, w_todo_rem;
  logic [W_COORD-1:0]   w_cur_row, w_cur_col;
  logic                 w_subtract;
  logic                 w_rect_hs, w_rd_hs;

  // Bounds compared one bit wider so x+w cannot wrap past the window edge.
  assign w_x_end   = {1'b0, rect_x} + {1'b0, rect_w};
  assign w_y_end   = {1'b0, rect_y} + {1'b0, rect_h};
  assign w_illegal = (rect_w == '0) || (rect_h == '0) ||
                     (w_x_end > (W_COORD+1)'(WINDOW_WIDTH)) ||
                     (w_y_end > (W_COORD+1)'(WINDOW_HEIGHT));

  // Lowest set bit of the to-do mask is the corner currently being fetched.
  assign w_cur      = r_todo & (~r_todo + 4'd1);
  assign w_todo_rem = r_todo & ~w_cur;
  assign w_cur_row  = (w_cur[0] || w_cur[2]) ? r_row_hi : r_row_lo;
  assign w_cur_col  = (w_cur[0] || w_cur[1]) ? r_col_hi : r_col_lo;
  assign w_subtract = w_cur[1] || w_cur[2];

  assign addr_data = W_ADDR'(w_cur_row) * W_ADDR'(WINDOW_WIDTH) + W_ADDR'(w_cur_col);
  assign sum_data  = r_acc;
  assign sum_err   = r_err;
  assign w_rect_hs = rect_valid && rect_ready;
  assign w_rd_hs   = rd_valid && rd_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_next     = r_state;
    rect_ready = 1'b0;
    addr_valid = 1'b0;
    rd_ready   = 1'b0;
    sum_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        rect_ready = 1'b1;
        if (rect_valid) w_next = w_illegal ? S_OUT : S_ADDR;
      end
      S_ADDR: begin
        addr_valid = 1'b1;
        if (addr_ready) w_next = S_DATA;
      end
      S_DATA: begin
        rd_ready = 1'b1;
        if (rd_valid) w_next = (w_todo_rem == 4'd0) ? S_OUT : S_ADDR;
      end
      S_OUT: begin
        sum_valid = 1'b1;
        if (sum_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_hi <= '0;
      r_row_lo <= '0;
      r_col_hi <= '0;
      r_col_lo <= '0;
      r_todo   <= '0;
      r_acc    <= '0;
      r_err    <= 1'b0;
    end else if (w_rect_hs) begin
      // Row/col -1 wrap harmlessly: those corners are masked out of r_todo.
      r_row_hi <= rect_y + rect_h - W_COORD'(1);
      r_row_lo <= rect_y - W_COORD'(1);
      r_col_hi <= rect_x + rect_w - W_COORD'(1);
      r_col_lo <= rect_x - W_COORD'(1);
      r_todo   <= w_illegal ? 4'd0 :
                  {(rect_x != '0) && (rect_y != '0), rect_x != '0, rect_y != '0, 1'b1};
      r_acc    <= '0;
      r_err    <= w_illegal;
    end else if (w_rd_hs) begin
      r_acc  <= w_subtract ? (r_acc - rd_data) : (r_acc + rd_data);
      r_todo <= w_todo_rem;
    end
  end

endmodule

// File: tb/tb_rect_sum_reader.sv
// Bench for rect_sum_reader: pixel-level image model, window-buffer responder
// with configurable stalls, directed corner cases and randomized descriptors.
module tb_rect_sum_reader;

  localparam int W_DATA  = 18;
  localparam int WW      = 24;
  localparam int WH      = 24;
  localparam int W_COORD = 5;
  localparam int W_ADDR  = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               rect_valid, rect_ready;
  logic [W_COORD-1:0] rect_x, rect_y, rect_w, rect_h;
  logic               addr_valid, addr_ready;
  logic [W_ADDR-1:0]  addr_data;
  logic               rd_valid, rd_ready;
  logic [W_DATA-1:0]  rd_data;
  logic               sum_valid, sum_ready;
  logic [W_DATA-1:0]  sum_data;
  logic               sum_err;

  rect_sum_reader #(.W_DATA(W_DATA), .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH)) dut (
    .clk(clk), .rst(rst),
    .rect_valid(rect_valid), .rect_ready(rect_ready),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_data(addr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_data(sum_data), .sum_err(sum_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Image model: pixels, and the integral image the buffer would hold.
  int unsigned       pix [WH][WW];
  logic [W_DATA-1:0] mem [WW*WH];

  task automatic load_image(input bit ones);
    logic [W_DATA-1:0] acc;
    for (int r = 0; r < WH; r++)
      for (int c = 0; c < WW; c++)
        pix[r][c] = ones ? 1 : $urandom_range(0, 1023);
    for (int r = 0; r < WH; r++)
      for (int c = 0; c < WW; c++) begin
        acc = '0;
        for (int rr = 0; rr <= r; rr++)
          for (int cc = 0; cc <= c; cc++)
            acc += W_DATA'(pix[rr][cc]);
        mem[r*WW + c] = acc;
      end
  endtask

  // Buffer responder knobs and expected address stream.
  int          addr_stall_cfg = 0;
  int          rd_delay_cfg   = 0;
  bit          junk_en        = 1'b0;
  int unsigned exp_addrs[$];
  int          addr_idx       = 0;

  initial begin
    bit               hs_a, hs_r, pending;
    int               a_wait, rd_cnt;
    logic [W_ADDR-1:0] pend_addr;
    pending = 1'b0; a_wait = 0; rd_cnt = 0; pend_addr = '0;
    addr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      hs_a = addr_valid && addr_ready;
      hs_r = rd_valid && rd_ready;
      if (addr_valid) begin
        if (addr_idx < exp_addrs.size()) check("addr_data", 32'(addr_data), exp_addrs[addr_idx]);
        else                             check("unexpected_addr_valid", 32'(addr_valid), 0);
      end
      if (hs_a) begin
        addr_idx++;
        pend_addr = addr_data;
      end
      @(posedge clk); #1;
      if (rst) begin
        pending = 1'b0; a_wait = 0; rd_valid = 1'b0; addr_ready = 1'b0;
        continue;
      end
      if (hs_a) begin
        pending = 1'b1; a_wait = 0; rd_cnt = rd_delay_cfg;
      end
      if (hs_r) pending = 1'b0;
      if (pending) begin
        if (rd_cnt == 0) begin
          rd_valid = 1'b1; rd_data = mem[pend_addr];
        end else begin
          rd_cnt--; rd_valid = 1'b0; rd_data = W_DATA'($urandom);
        end
      end else begin
        // Spurious returns outside a fetch must be ignored by the reader.
        rd_valid = junk_en && ($urandom_range(0, 1) == 1);
        rd_data  = W_DATA'($urandom);
      end
      addr_ready = (a_wait >= addr_stall_cfg);
      if (addr_valid && !addr_ready) a_wait++;
    end
  end

  // Reference: corner list from the descriptor, sum straight from pixels.
  task automatic set_expect(input int x, y, w, h, output bit legal, output logic [W_DATA-1:0] exp_sum);
    legal   = (w > 0) && (h > 0) && (x + w <= WW) && (y + h <= WH);
    exp_sum = '0;
    exp_addrs.delete();
    addr_idx = 0;
    if (legal) begin
      exp_addrs.push_back((y+h-1)*WW + (x+w-1));
      if (y > 0)          exp_addrs.push_back((y-1)*WW + (x+w-1));
      if (x > 0)          exp_addrs.push_back((y+h-1)*WW + (x-1));
      if (x > 0 && y > 0) exp_addrs.push_back((y-1)*WW + (x-1));
      for (int r = y; r < y + h; r++)
        for (int c = x; c < x + w; c++)
          exp_sum += W_DATA'(pix[r][c]);
    end
  endtask

  task automatic send_rect(input int x, y, w, h, output int n_acc);
    bit got;
    got = 1'b0; n_acc = 0;
    @(posedge clk); #1;
    rect_valid = 1'b1;
    rect_x = W_COORD'(x); rect_y = W_COORD'(y);
    rect_w = W_COORD'(w); rect_h = W_COORD'(h);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rect_ready) begin
        got = 1'b1; n_acc = cyc;
      end
      @(posedge clk); #1;
    end
    check("rect_accept", 32'(got), 1);
    rect_valid = 1'b0;
    rect_x = W_COORD'($urandom); rect_y = W_COORD'($urandom);
    rect_w = W_COORD'($urandom); rect_h = W_COORD'($urandom);
  endtask

  task automatic run_rect(input int x, y, w, h, input int a_st, r_dl, s_st);
    bit                legal, got;
    logic [W_DATA-1:0] exp_sum, exp_val;
    int                n_acc, m_sv, sv_seen, k;
    set_expect(x, y, w, h, legal, exp_sum);
    exp_val = legal ? exp_sum : '0;
    k = exp_addrs.size();
    addr_stall_cfg = a_st;
    rd_delay_cfg   = r_dl;
    sum_ready = (s_st == 0);
    send_rect(x, y, w, h, n_acc);
    got = 1'b0; sv_seen = 0; m_sv = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (sum_valid) begin
        if (sv_seen == 0) m_sv = cyc;
        check("sum_data", 32'(sum_data), 32'(exp_val));
        check("sum_err", 32'(sum_err), 32'(!legal));
        if (sum_ready) got = 1'b1;
        sv_seen++;
      end
      @(posedge clk); #1;
      sum_ready = (sv_seen >= s_st);
    end
    sum_ready = 1'b0;
    check("sum_handshake", 32'(got), 1);
    check("addr_count", 32'(addr_idx), 32'(k));
    if (a_st == 0 && r_dl == 0 && s_st == 0)
      check("latency", 32'(m_sv - n_acc), 32'(1 + 2*k));
    check("back_to_idle", 32'(sum_valid), 0);
    check("ready_after_out", 32'(rect_ready), 1);
  endtask

  initial begin
    int          x, y, w, h, n_acc;
    bit          legal, got;
    logic [W_DATA-1:0] exp_sum;
    rst = 1'b1; rect_valid = 1'b0; sum_ready = 1'b0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0;
    load_image(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rect_ready", 32'(rect_ready), 1);
    check("rst_addr_valid", 32'(addr_valid), 0);
    check("rst_rd_ready", 32'(rd_ready), 0);
    check("rst_sum_valid", 32'(sum_valid), 0);
    check("rst_sum_data", 32'(sum_data), 0);
    check("rst_sum_err", 32'(sum_err), 0);
    rst = 1'b0;

    // Directed cases on the all-ones image.
    run_rect(2, 3, 4, 5, 0, 0, 0);
    run_rect(0, 0, 24, 24, 0, 0, 0);
    run_rect(0, 4, 3, 2, 0, 0, 0);
    run_rect(20, 0, 5, 1, 0, 0, 0);
    run_rect(3, 3, 4, 0, 0, 0, 0);
    run_rect(5, 0, 0, 3, 0, 0, 0);
    run_rect(0, 23, 24, 1, 0, 0, 0);
    run_rect(23, 23, 1, 1, 0, 0, 0);
    run_rect(2, 3, 4, 5, 3, 2, 4);

    // Reset while waiting for a returned value.
    set_expect(2, 3, 4, 5, legal, exp_sum);
    addr_stall_cfg = 0;
    rd_delay_cfg   = 8;
    send_rect(2, 3, 4, 5, n_acc);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_ready) got = 1'b1;
    end
    check("reached_data", 32'(got), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rect_ready", 32'(rect_ready), 1);
    check("mid_rst_addr_valid", 32'(addr_valid), 0);
    check("mid_rst_rd_ready", 32'(rd_ready), 0);
    check("mid_rst_sum_valid", 32'(sum_valid), 0);
    check("mid_rst_sum_data", 32'(sum_data), 0);
    @(negedge clk);
    rst = 1'b0;
    run_rect(2, 3, 4, 5, 0, 0, 0);

    // Randomized descriptors, random images, random stalls.
    junk_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (t % 20 == 0) load_image(1'b0);
      if ($urandom_range(0, 4) == 0) begin
        x = $urandom_range(0, 31); y = $urandom_range(0, 31);
        w = $urandom_range(0, 31); h = $urandom_range(0, 31);
      end else begin
        w = $urandom_range(1, WW); h = $urandom_range(1, WH);
        x = $urandom_range(0, WW - w); y = $urandom_range(0, WH - h);
      end
      if ($urandom_range(0, 1) == 0) run_rect(x, y, w, h, 0, 0, 0);
      else run_rect(x, y, w, h, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
